// File: rtl/dmx_rx_slot_writer_if.sv
// EBR write port between the DMX receiver and the dimming-data RAM.
// One strobe per received byte; address 0 is the start code.
interface dmx_rx_slot_writer_if;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        input wr_en,
        input wr_addr,
        input wr_data
    );
endinterface

// File: rtl/dmx_rx_slot_writer.sv
// DMX512 receive front end: break/MAB detection, 8N2 byte decoding,
// and slot writes into the dimming-data EBR (addr 0 = start code).
module dmx_rx_slot_writer #(
    parameter int CLK_FREQ     = 12000000,
    parameter int BAUD_RATE    = 250000,
    parameter int BREAK_MIN_US = 88,
    parameter int MAB_MIN_US   = 8,
    parameter bit NULL_SC_ONLY = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   dmx_in,
    dmx_rx_slot_writer_if.master   wr,
    output logic                   frame_done,
    output logic [9:0]             slot_count,
    output logic [7:0]             start_code,
    output logic                   rx_err,
    output logic                   busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int BREAK_CLKS   = BREAK_MIN_US * (CLK_FREQ / 1000) / 1000;
    localparam int MAB_CLKS     = MAB_MIN_US * (CLK_FREQ / 1000) / 1000;
    localparam int LW = $clog2(BREAK_CLKS + 1);
    localparam int TW = $clog2(MAB_CLKS + CLKS_PER_BIT + 1);

    localparam logic [LW-1:0] LR_MAX = LW'(BREAK_CLKS);
    localparam logic [LW-1:0] LR_PRE = LW'(BREAK_CLKS - 1);
    localparam logic [TW-1:0] BT_MAX = '1;
    localparam logic [TW-1:0] BT_MAB = TW'(MAB_CLKS);
    localparam logic [TW-1:0] BT_HALF = TW'(HALF_BIT);
    localparam logic [TW-1:0] BT_BIT = TW'(CLKS_PER_BIT);
    localparam logic [TW-1:0] BT_ONE = TW'(1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] BREAK    = 3'd1;
    localparam logic [2:0] MAB      = 3'd2;
    localparam logic [2:0] START    = 3'd3;
    localparam logic [2:0] DATA     = 3'd4;
    localparam logic [2:0] STOP     = 3'd5;
    localparam logic [2:0] GAP      = 3'd6;
    localparam logic [2:0] WAIT_BRK = 3'd7;

    logic          sync1;
    logic          rx_s;
    logic          rx_q;
    logic [LW-1:0] low_run;
    logic [TW-1:0] bt;
    logic [2:0]    state;
    logic [2:0]    bit_idx;
    logic [7:0]    sr;
    logic [9:0]    byte_idx;
    logic          last_pend;
    logic          fall;
    logic          brk_now;

    assign fall = rx_q & ~rx_s;
    // low_run reaches the break threshold on the coming edge
    assign brk_now = ~rx_s & (low_run == LR_PRE);

    // Two-stage synchronizer, plus a delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            rx_q  <= 1'b1;
        end else begin
            sync1 <= dmx_in;
            rx_s  <= sync1;
            rx_q  <= rx_s;
        end
    end

    // Saturating count of consecutive low line cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_run <= '0;
        end else if (rx_s) begin
            low_run <= '0;
        end else if (low_run != LR_MAX) begin
            low_run <= low_run + 1'b1;
        end
    end

    // Frame FSM, byte assembly and EBR write / status generation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bt         <= '0;
            bit_idx    <= '0;
            sr         <= '0;
            byte_idx   <= '0;
            last_pend  <= 1'b0;
            wr.wr_en   <= 1'b0;
            wr.wr_addr <= '0;
            wr.wr_data <= '0;
            frame_done <= 1'b0;
            slot_count <= '0;
            start_code <= '0;
            rx_err     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            wr.wr_en   <= 1'b0;
            frame_done <= 1'b0;
            rx_err     <= 1'b0;
            last_pend  <= 1'b0;
            if (bt != BT_MAX) bt <= bt + 1'b1;
            if (!enable) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                if (last_pend) begin
                    frame_done <= 1'b1;
                    slot_count <= 10'd512;
                end
                if (brk_now && state != BREAK) begin
                    state <= BREAK;
                    busy  <= 1'b0;
                    if (busy && byte_idx != 10'd0) begin
                        frame_done <= 1'b1;
                        slot_count <= byte_idx - 10'd1;
                    end
                end else begin
                    unique case (state)
                        IDLE: ;
                        BREAK: begin
                            if (rx_s) begin
                                state <= MAB;
                                bt    <= BT_ONE;
                            end
                        end
                        MAB: begin
                            if (fall) begin
                                if (bt >= BT_MAB) begin
                                    state    <= START;
                                    bt       <= BT_ONE;
                                    busy     <= 1'b1;
                                    byte_idx <= '0;
                                end else begin
                                    state <= IDLE;
                                end
                            end
                        end
                        START: begin
                            if (bt == BT_HALF) begin
                                if (rx_s) begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end else begin
                                    state   <= DATA;
                                    bt      <= BT_ONE;
                                    bit_idx <= '0;
                                end
                            end
                        end
                        DATA: begin
                            if (bt == BT_BIT) begin
                                sr      <= {rx_s, sr[7:1]};
                                bt      <= BT_ONE;
                                bit_idx <= bit_idx + 1'b1;
                                if (bit_idx == 3'd7) state <= STOP;
                            end
                        end
                        STOP: begin
                            if (bt == BT_BIT) begin
                                if (!rx_s) begin
                                    state <= WAIT_BRK;
                                end else begin
                                    if (byte_idx == 10'd0) start_code <= sr;
                                    if (NULL_SC_ONLY && byte_idx == 10'd0
                                        && sr != 8'h00) begin
                                        state <= IDLE;
                                        busy  <= 1'b0;
                                    end else begin
                                        wr.wr_en   <= 1'b1;
                                        wr.wr_addr <= byte_idx;
                                        wr.wr_data <= sr;
                                        byte_idx   <= byte_idx + 10'd1;
                                        if (byte_idx == 10'd512) begin
                                            state     <= IDLE;
                                            busy      <= 1'b0;
                                            last_pend <= 1'b1;
                                        end else begin
                                            state <= GAP;
                                        end
                                    end
                                end
                            end
                        end
                        GAP: begin
                            if (fall) begin
                                state <= START;
                                bt    <= BT_ONE;
                            end
                        end
                        WAIT_BRK: begin
                            if (rx_s) begin
                                rx_err <= 1'b1;
                                busy   <= 1'b0;
                                state  <= IDLE;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_dmx_rx_slot_writer.sv
// Scoreboard bench for dmx_rx_slot_writer at 1 MHz / 250 kbaud,
// so one clock is one microsecond and a bit is 4 clocks.
`timescale 1ns/1ps
module tb_dmx_rx_slot_writer;
    localparam int CPB = 4;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int slots;
        int sc;
    } fd_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       dmx = 1'b1;
    logic       frame_done, rx_err, busy;
    logic [9:0] slot_count;
    logic [7:0] start_code;
    logic       fd_n, err_n, busy_n;
    logic [9:0] slots_n;
    logic [7:0] sc_n;

    wr_t exp_wr[$];
    fd_t exp_fd[$];
    wr_t ew;
    fd_t ef;
    int  n_chk = 0;
    int  n_pass = 0;
    int  n_err = 0;
    int  n_wr_n = 0;
    int  n_fd_n = 0;
    int  cyc = 0;
    int  last_wr_cyc = 0;

    dmx_rx_slot_writer_if wif();
    dmx_rx_slot_writer_if wif_n();

    dmx_rx_slot_writer #(
        .CLK_FREQ(1000000), .BAUD_RATE(250000),
        .BREAK_MIN_US(88), .MAB_MIN_US(8), .NULL_SC_ONLY(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .dmx_in(dmx),
        .wr(wif), .frame_done(frame_done), .slot_count(slot_count),
        .start_code(start_code), .rx_err(rx_err), .busy(busy)
    );

    dmx_rx_slot_writer #(
        .CLK_FREQ(1000000), .BAUD_RATE(250000),
        .BREAK_MIN_US(88), .MAB_MIN_US(8), .NULL_SC_ONLY(1'b1)
    ) dut_n (
        .clk(clk), .rst_n(rst_n), .enable(1'b1), .dmx_in(dmx),
        .wr(wif_n), .frame_done(fd_n), .slot_count(slots_n),
        .start_code(sc_n), .rx_err(err_n), .busy(busy_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                      tag, got, got, exp, exp);
    endtask

    task automatic hold(input logic v, input int n);
        dmx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic brk(input int lo, input int mab);
        hold(1'b0, lo);
        hold(1'b1, mab);
    endtask

    task automatic send_byte(input logic [7:0] b, input int stop_lo);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        if (stop_lo > 0) hold(1'b0, stop_lo);
        hold(1'b1, 2 * CPB);
    endtask

    task automatic send_exp(input int addr, input logic [7:0] b);
        exp_wr.push_back('{addr, int'(b)});
        send_byte(b, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr_en"}, int'(wif.wr_en), 0);
        chk({tag, "_wr_addr"}, int'(wif.wr_addr), 0);
        chk({tag, "_wr_data"}, int'(wif.wr_data), 0);
        chk({tag, "_fd"}, int'(frame_done), 0);
        chk({tag, "_slots"}, int'(slot_count), 0);
        chk({tag, "_sc"}, int'(start_code), 0);
        chk({tag, "_err"}, int'(rx_err), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    // Output monitor: pops scoreboard entries as the DUT produces them
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n) begin
            if (wif.wr_en) begin
                if (exp_wr.size() == 0) begin
                    chk("wr_extra", int'(wif.wr_addr), -1);
                end else begin
                    ew = exp_wr.pop_front();
                    chk("wr_addr", int'(wif.wr_addr), ew.addr);
                    chk("wr_data", int'(wif.wr_data), ew.data);
                end
                last_wr_cyc = cyc;
            end
            if (frame_done) begin
                if (exp_fd.size() == 0) begin
                    chk("fd_extra", int'(slot_count), -1);
                end else begin
                    ef = exp_fd.pop_front();
                    chk("fd_slots", int'(slot_count), ef.slots);
                    chk("fd_sc", int'(start_code), ef.sc);
                    if (ef.slots == 512)
                        chk("fd_lat", cyc - last_wr_cyc, 1);
                end
            end
            if (rx_err) n_err++;
            if (wif_n.wr_en) n_wr_n++;
            if (fd_n) n_fd_n++;
        end
    end

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: cycle budget expired");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_zero("rst");
        rst_n = 1'b1;
        enable = 1'b1;
        hold(1'b1, 20);

        // Short frame closed by the next break
        brk(100, 12);
        send_exp(0, 8'h00);
        send_exp(1, 8'h11);
        send_exp(2, 8'h22);
        send_exp(3, 8'h33);
        hold(1'b1, 50);
        exp_fd.push_back('{3, 0});
        brk(100, 12);
        chk("t1_fd_q", exp_fd.size(), 0);

        // Full 512-slot frame, then an extra byte that must be ignored
        exp_fd.push_back('{512, 0});
        send_exp(0, 8'h00);
        for (int i = 1; i <= 512; i++) send_exp(i, 8'(i));
        send_byte(8'hEE, 0);
        hold(1'b1, 20);
        chk("t2_wr_q", exp_wr.size(), 0);
        chk("t2_fd_q", exp_fd.size(), 0);
        chk("t2_slots", int'(slot_count), 512);
        chk("t2_busy", int'(busy), 0);

        // Short break, then short MAB: both rejected
        brk(50, 12);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        hold(1'b1, 20);
        brk(100, 4);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        hold(1'b1, 20);
        chk("t3_busy", int'(busy), 0);
        chk("t3_slots", int'(slot_count), 512);

        // Stop bit held low after two slots
        brk(100, 12);
        send_exp(0, 8'h00);
        send_exp(1, 8'h01);
        send_exp(2, 8'h02);
        send_byte(8'h03, 30);
        hold(1'b1, 20);
        chk("t4_err", n_err, 1);
        chk("t4_busy", int'(busy), 0);
        chk("t4_slots", int'(slot_count), 512);

        // Recovery frame, then enable dropped mid-frame
        brk(100, 12);
        send_exp(0, 8'h00);
        send_exp(1, 8'h05);
        send_exp(2, 8'h06);
        exp_fd.push_back('{2, 0});
        brk(100, 12);
        chk("t5_slots_a", int'(slot_count), 2);
        send_exp(0, 8'h00);
        for (int i = 1; i <= 5; i++) send_exp(i, 8'(i));
        enable = 1'b0;
        fork
            begin
                repeat (10) @(negedge clk);
                enable = 1'b1;
            end
        join_none
        for (int i = 6; i <= 9; i++) send_byte(8'(i), 0);
        hold(1'b1, 20);
        chk("t5_busy", int'(busy), 0);
        chk("t5_wr_q", exp_wr.size(), 0);
        brk(100, 12);
        chk("t5_fd_q", exp_fd.size(), 0);
        send_exp(0, 8'h00);
        for (int i = 1; i <= 7; i++) send_exp(i, 8'(i));
        exp_fd.push_back('{7, 0});
        brk(100, 12);
        chk("t5_slots_b", int'(slot_count), 7);

        // Non-null start code: the NULL_SC_ONLY instance stores nothing
        n_wr_n = 0;
        n_fd_n = 0;
        send_exp(0, 8'hCC);
        send_exp(1, 8'h01);
        send_exp(2, 8'h02);
        send_exp(3, 8'h03);
        hold(1'b1, 20);
        chk("t6_sc_n", int'(sc_n), 8'hCC);
        chk("t6_wr_n", n_wr_n, 0);
        chk("t6_fd_n", n_fd_n, 0);
        chk("t6_sc", int'(start_code), 8'hCC);

        // Reset in the middle of a slot
        exp_fd.push_back('{3, 8'hCC});
        brk(100, 12);
        send_exp(0, 8'h00);
        hold(1'b0, CPB);
        hold(1'b1, CPB);
        chk("t7_busy_pre", int'(busy), 1);
        chk("t7_slots_pre", int'(slot_count), 3);
        rst_n = 1'b0;
        #1;
        chk_zero("t7");
        chk("end_wr_q", exp_wr.size(), 0);
        chk("end_fd_q", exp_fd.size(), 0);
        chk("end_err", n_err, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
